snes_controller_emulator: RTL and testbench

- Device-side SNES controller: answers a console (or a host controller-reader) that drives latch and clock, and shifts out 16 active-low button bits on the data line.
- Lets the FPGA present its internal button state (12 SNES buttons) as a real controller to an external SNES-protocol host.
- Host-facing pins are asynchronous; the block oversamples them on the system clock.

---
 rtl/snes_pkg.sv | 36 +++
 rtl/async_edge_sync.sv | 39 +++
 rtl/snes_controller_emulator.sv | 144 ++++++++++++++
 tb/tb_snes_controller_emulator.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/snes_pkg.sv
// snes_pkg: shared definitions for the SNES controller protocol.
// Button bit indices (shared with the host-side reader), frame length,
// device FSM state encoding and a helper that builds the serial frame word.
package snes_pkg;

  localparam int SNES_B      = 0;
  localparam int SNES_Y      = 1;
  localparam int SNES_SELECT = 2;
  localparam int SNES_START  = 3;
  localparam int SNES_UP     = 4;
  localparam int SNES_DOWN   = 5;
  localparam int SNES_LEFT   = 6;
  localparam int SNES_RIGHT  = 7;
  localparam int SNES_A      = 8;
  localparam int SNES_X      = 9;
  localparam int SNES_L      = 10;
  localparam int SNES_R      = 11;

  localparam int SNES_BUTTONS    = 12;
  localparam int SNES_FRAME_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } snes_state_t;

  // Wire format is active-low; the four unused trailing bits read as released.
  function automatic logic [SNES_FRAME_BITS-1:0] snes_frame_word(
    input logic [SNES_BUTTONS-1:0] pressed
  );
    return {4'b1111, ~pressed};
  endfunction

endpackage

// File: rtl/async_edge_sync.sv
// async_edge_sync: brings an asynchronous pin into the clock domain and
// flags its edges.
//   clock  in   system clock
//   reset  in   synchronous active-high reset; presets all flops to PRESET
//   pin    in   asynchronous input
//   rise   out  one-cycle pulse on a synchronized 0->1 transition
//   fall   out  one-cycle pulse on a synchronized 1->0 transition
// Presetting to the pin's idle level keeps reset release from producing a
// spurious edge.
module async_edge_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic PRESET      = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   level;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{PRESET}};
      hist_q <= PRESET;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/snes_controller_emulator.sv
// snes_controller_emulator: device side of the SNES controller protocol.
// Presents the internal button state to an external host that drives latch
// and clock, shifting 16 active-low bits out LSB first.
//   clock        in   system clock (>= 8x host clock rate)
//   reset        in   synchronous active-high reset
//   buttons      in   [11:0] active-high pressed, indexed per snes_pkg
//   snes_latch   in   host latch, asynchronous, active-high
//   snes_clock   in   host serial clock, asynchronous, idles high
//   snes_data    out  registered serial data, 0 = pressed
//   poll_strobe  out  one-cycle pulse when the host latch falls
//   busy         out  high while in LATCH or SHIFT
//
// state | meaning
// IDLE  | no frame in progress, data line released high
// LATCH | host latch high, frame word reloaded every cycle
// SHIFT | snapshot frozen, one bit shifted per host clock rise
// DONE  | all 16 bits sent, FILL_BIT driven until the next latch
module snes_controller_emulator
  import snes_pkg::*;
#(
  parameter int   SYNC_STAGES    = 2,
  parameter int   TIMEOUT_CYCLES = 65535,
  parameter logic FILL_BIT       = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SNES_BUTTONS-1:0] buttons,
  input  logic                    snes_latch,
  input  logic                    snes_clock,
  output logic                    snes_data,
  output logic                    poll_strobe,
  output logic                    busy
);

  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]     LAST_BIT = 5'(SNES_FRAME_BITS - 1);

  snes_state_t                state_q, state_d;
  logic [SNES_FRAME_BITS-1:0] shift_q, shift_d;
  logic [SNES_FRAME_BITS-1:0] frame;
  logic [4:0]                 count_q, count_d;
  logic [TW-1:0]              tmo_q, tmo_d;
  logic                       data_d, strobe_d, busy_d;
  logic                       rise_latch, fall_latch, rise_clk, fall_clk_unused;
  logic                       rise_latch_unused;
  logic                       shifting;

  async_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .PRESET(1'b0)) u_latch_sync (
    .clock (clock),
    .reset (reset),
    .pin   (snes_latch),
    .rise  (rise_latch),
    .fall  (fall_latch)
  );

  async_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .PRESET(1'b1)) u_clock_sync (
    .clock (clock),
    .reset (reset),
    .pin   (snes_clock),
    .rise  (rise_clk),
    .fall  (fall_clk_unused)
  );

  // The host samples on its falling edge; only the rising edge matters here.
  assign rise_latch_unused = fall_clk_unused;

  assign frame    = snes_frame_word(buttons);
  // A latch rise in the same cycle as a clock rise aborts the frame instead.
  assign shifting = (state_q == ST_SHIFT) && rise_clk && !rise_latch;

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (rise_latch) state_d = ST_LATCH;
      ST_LATCH: if (fall_latch) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (rise_latch)                        state_d = ST_LATCH;
        else if (rise_clk && count_q == LAST_BIT) state_d = ST_DONE;
        else if (!rise_clk && tmo_q >= TMO_LAST)  state_d = ST_IDLE;
      end
      ST_DONE:  if (rise_latch) state_d = ST_LATCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: LATCH keeps reloading so the snapshot taken on
  // exit reflects the buttons in the cycle the latch fell.
  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    tmo_d   = tmo_q;
    if (state_d == ST_LATCH || state_q == ST_LATCH) begin
      shift_d = frame;
      count_d = '0;
      tmo_d   = '0;
    end else if (shifting) begin
      shift_d = {1'b1, shift_q[SNES_FRAME_BITS-1:1]};
      count_d = count_q + 5'd1;
      tmo_d   = '0;
    end else if (state_q == ST_SHIFT && tmo_q != '1) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Outputs are decoded from next-state values so the registered pins line
  // up with the state they describe.
  always_comb begin
    data_d   = 1'b1;
    strobe_d = (state_q == ST_LATCH) && (state_d == ST_SHIFT);
    busy_d   = (state_d == ST_LATCH) || (state_d == ST_SHIFT);
    case (state_d)
      ST_IDLE:  data_d = 1'b1;
      ST_LATCH: data_d = frame[0];
      ST_SHIFT: data_d = shift_d[0];
      ST_DONE:  data_d = FILL_BIT;
      default:  data_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q     <= '1;
      count_q     <= '0;
      tmo_q       <= '0;
      snes_data   <= 1'b1;
      poll_strobe <= 1'b0;
      busy        <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      count_q     <= count_d;
      tmo_q       <= tmo_d;
      snes_data   <= data_d ^ (rise_latch_unused & 1'b0);
      poll_strobe <= strobe_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_snes_controller_emulator.sv
// tb_snes_controller_emulator: drives host latch/clock sequences against the
// emulator. Expected bits are queued when a frame is issued; a monitor pops
// and compares on every host clock falling edge, where the host samples.
module tb_snes_controller_emulator;

  localparam int   TMO  = 100;
  localparam int   HALF = 12;
  localparam logic FILL = 1'b0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] buttons = 12'h000;
  logic        snes_latch = 1'b0;
  logic        snes_clock = 1'b1;
  logic        snes_data, poll_strobe, busy;

  int   total = 0;
  int   bad   = 0;
  int   strobes = 0;
  logic exp_q[$];

  snes_controller_emulator #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TMO),
    .FILL_BIT       (FILL)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .buttons     (buttons),
    .snes_latch  (snes_latch),
    .snes_clock  (snes_clock),
    .snes_data   (snes_data),
    .poll_strobe (poll_strobe),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (poll_strobe) strobes++;

  // Host-side sampling monitor.
  always @(negedge snes_clock) begin
    logic exp_bit;
    if (!reset) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL bit_unexpected: got %b with no expected bit queued", snes_data);
      end else begin
        exp_bit = exp_q.pop_front();
        if (snes_data !== exp_bit) begin
          bad++;
          $display("FAIL bit_sample: got %b expected %b", snes_data, exp_bit);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One host poll: latch pulse then nclk clock pulses. chg >= 0 clears the
  // buttons just before that clock pulse to prove the snapshot is frozen.
  task automatic frame(input logic [11:0] b, input int nclk, input int chg);
    logic [15:0] w;
    int          s0;
    w  = {4'hF, ~b};
    s0 = strobes;
    buttons = b;
    for (int i = 0; i < nclk; i++) exp_q.push_back(w[i]);
    snes_latch = 1'b1;
    cycles(20);
    check("latch_busy", 32'(busy), 32'd1);
    check("latch_data", 32'(snes_data), 32'(w[0]));
    cycles(4);
    snes_latch = 1'b0;
    cycles(HALF);
    check("poll_strobe_once", 32'(strobes), 32'(s0 + 1));
    for (int k = 0; k < nclk; k++) begin
      if (k == chg) buttons = 12'h000;
      snes_clock = 1'b0;
      cycles(HALF);
      snes_clock = 1'b1;
      cycles(HALF);
    end
    if (nclk == 16) begin
      check("done_data", 32'(snes_data), 32'(FILL));
      check("done_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    cycles(4);
    reset = 1'b0;
    cycles(20);
    check("idle_data", 32'(snes_data), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_no_strobe", 32'(strobes), 32'd0);

    // Only B pressed: bit 0 low, all others high.
    frame(12'h001, 16, -1);

    // Mixed pattern, buttons cleared mid-frame.
    frame(12'hA5A, 16, 6);

    // Host aborts after 5 bits; next frame restarts cleanly at bit 0.
    frame(12'h3C0, 5, -1);
    frame(12'h003, 16, -1);

    // Timeout: latch falls, host never clocks.
    buttons = 12'h000;
    snes_latch = 1'b1;
    cycles(24);
    snes_latch = 1'b0;
    cycles(50);
    check("tmo_pending_busy", 32'(busy), 32'd1);
    check("tmo_pending_data", 32'(snes_data), 32'd1);
    cycles(60);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_data", 32'(snes_data), 32'd1);

    // Reset during bit 7, then a full clean frame.
    frame(12'h0F0, 7, -1);
    exp_q.push_back(1'b0);
    snes_clock = 1'b0;
    cycles(6);
    reset = 1'b1;
    cycles(1);
    check("rst_data", 32'(snes_data), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    cycles(2);
    snes_clock = 1'b1;
    cycles(30);
    check("post_rst_data", 32'(snes_data), 32'd1);
    frame(12'h0F0, 16, -1);

    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
